sram_dma_port_arbiter: RTL
==========================

# sram_dma_port_arbiter

- Shares one single-port on-chip SRAM between two requesters:
  - Port A: the AHB-to-SRAM bridge's SRAM-side signals.
  - Port B: a DMA word-access port.
- Port A has fixed priority and passes through combinationally. Port B is granted any cycle port A leaves the SRAM unselected.
- A starvation counter holds off the AHB bus for two cycles through `AHB_STALL` (ANDed into the bridge's `HREADYOUT` by the subsystem wrapper), so that DMA progress is guaranteed.
- Sits between the SRAM bridge, the DMA engine and the SRAM macro in the DMA subsystem.

## Interface
- `AW`, 16: byte address width; SRAM word address is `AW-2` bits.
- `STARVE_LIMIT`, 8: consecutive blocked port-B request cycles that trigger a stall; legal range 2..255.
- `HCLK` in 1: system clock.
- `HRESET` in 1: reset, asynchronous, active-high.
- `A_SRAMCS` in 1: bridge chip select.
- `A_SRAMWEN` in 4: bridge byte write enables.
- `A_SRAMADDR` in AW-2: bridge word address.
- `A_SRAMWDATA` in 32: bridge write data.
- `A_SRAMRDATA` out 32: read data to bridge.
- `B_REQ` in 1: DMA access request.
- `B_WRITE` in 1: 1 = write, 0 = read.
- `B_WEN` in 4: DMA byte strobes (writes only).
- `B_ADDR` in AW-2: DMA word address.
- `B_WDATA` in 32: DMA write data.
- `B_GNT` out 1: access taken this cycle.
- `B_RVALID` out 1: `B_RDATA` valid.
- `B_RDATA` out 32: read data to DMA.
- `SRAMCS` out 1: SRAM chip select.
- `SRAMWEN` out 4: SRAM byte write enables.
- `SRAMADDR` out AW-2: SRAM word address.
- `SRAMWDATA` out 32: SRAM write data.
- `SRAMRDATA` in 32: SRAM read data, valid the cycle after a read select.
- `AHB_STALL` out 1: registered; holds the AHB data phase (`HREADYOUT` forced low).
- `STARVE_CNT_SAT` out 1: registered sticky flag; set when a stall is issued, cleared only by reset.

## Operation
- **Grant:** `B_GNT = B_REQ & ~A_SRAMCS`, combinational.
- **SRAM mux:**
  - `A_SRAMCS` high: `SRAM*` = `A_*`.
  - Else `B_GNT` high: `SRAMCS`=1, `SRAMADDR`=`B_ADDR`, `SRAMWDATA`=`B_WDATA`, `SRAMWEN`=`B_WRITE ? B_WEN : 4'b0000`.
  - Else `SRAMCS`=0, `SRAMWEN`=0, and address/data follow port A.
- **Read data:**
  - `A_SRAMRDATA` = `B_RDATA` = `SRAMRDATA`, pass-through.
  - `B_RVALID` is a register, set to `B_GNT & ~B_WRITE` each cycle.
- **Handshake:** DMA holds `B_REQ`, `B_WRITE`, `B_WEN`, `B_ADDR`, `B_WDATA` stable until `B_GNT`. A new word may be presented the cycle after `B_GNT`. Back-to-back grants give one word per cycle.
- **FSM states:** IDLE, WAIT, STALL1, STALL2. Counter `cnt` is 8 bits.
  - IDLE: `cnt`=0. `B_REQ & A_SRAMCS` → WAIT with `cnt`=1. Otherwise stay in IDLE.
  - WAIT:
    - `B_GNT` or `~B_REQ` → IDLE.
    - Else if `cnt == STARVE_LIMIT` → STALL1.
    - Else `cnt`+1.
  - STALL1 → STALL2 unconditionally. The bridge flushes its pending buffered write here.
  - STALL2 → IDLE. Port A is idle here, so a held `B_REQ` is granted. If `A_SRAMCS` is still high (protocol violation), there is no grant and counting restarts from IDLE.
  - `AHB_STALL` = 1 in STALL1 and STALL2, else 0. It is driven from the next-state register, so it is never combinational.
- **Simultaneous events:**
  - Port A always wins.
  - If `B_REQ` drops while in WAIT, the arbiter returns to IDLE without a stall.
  - The counter never wraps; it saturates into a stall.
- **Reset (`HRESET` high, any time):**
  - FSM → IDLE, `cnt`=0.
  - `AHB_STALL`=0, `B_RVALID`=0, `STARVE_CNT_SAT`=0.
  - Combinational outputs follow the rules above. With all inputs low, `SRAMCS`=0, `SRAMWEN`=0, `B_GNT`=0.
  - An in-flight DMA read loses its `B_RVALID`; the DMA re-issues it.

## Timing
- Port A path is zero added latency, combinational; `A_SRAMRDATA` timing is unchanged.
- Port B read: `B_GNT` in cycle N, `B_RVALID` and `B_RDATA` in cycle N+1.
- Port B write: committed to SRAM in the `B_GNT` cycle.
- Worst-case grant latency: `STARVE_LIMIT` + 2 cycles from `B_REQ` under continuous AHB traffic.
- `AHB_STALL` pulse width is exactly 2 cycles. Minimum spacing between pulses is `STARVE_LIMIT` + 1 cycles.

## Test plan
- **Idle bus:** `A_SRAMCS`=0, DMA read at addr 0x010.
  - Same cycle: `B_GNT`=1, `SRAMADDR`=0x010, `SRAMWEN`=0.
  - Next cycle: `B_RVALID`=1 and `B_RDATA`=`SRAMRDATA`.
- **Collision:** `A_SRAMCS`=1 with `A_SRAMWEN`=4'b1111 and a DMA write pending.
  - SRAM shows port A, `B_GNT`=0.
  - The cycle `A_SRAMCS` drops: `B_GNT`=1 and `SRAMWEN`=`B_WEN`.
- **Starvation, `STARVE_LIMIT`=4:** continuous `A_SRAMCS`=1 with `B_REQ` held.
  - `AHB_STALL` high exactly 2 cycles, starting 5 cycles after `B_REQ`.
  - Bench drops `A_SRAMCS` in STALL2; `B_GNT`=1 there and `STARVE_CNT_SAT`=1.
- **Request withdrawn:** `B_REQ` dropped after 3 blocked cycles (`STARVE_LIMIT`=4) → no `AHB_STALL`, FSM back to IDLE.
- **Burst:** 8 back-to-back DMA reads on an idle bus → 8 consecutive `B_GNT`, then 8 consecutive `B_RVALID` shifted by one cycle.
- **Reset mid-stall:** `HRESET` asserted in STALL1 → `AHB_STALL`=0 and `B_RVALID`=0 immediately (asynchronous); FSM in IDLE after release.

Source files
------------

// File: rtl/sram_dma_port_arbiter_if.sv
// SRAM-side bundle shared by the AHB bridge (port A), the DMA word port (port B) and the SRAM macro.
// The slave modport is the arbiter's view; master is the view of the surrounding subsystem.
interface sram_dma_port_arbiter_if #(
  parameter int unsigned AW = 16
);
  localparam int unsigned WAW = AW - 2;

  // Port A: AHB-to-SRAM bridge
  logic           A_SRAMCS;
  logic [3:0]     A_SRAMWEN;
  logic [WAW-1:0] A_SRAMADDR;
  logic [31:0]    A_SRAMWDATA;
  logic [31:0]    A_SRAMRDATA;

  // Port B: DMA word access
  logic           B_REQ;
  logic           B_WRITE;
  logic [3:0]     B_WEN;
  logic [WAW-1:0] B_ADDR;
  logic [31:0]    B_WDATA;
  logic           B_GNT;
  logic           B_RVALID;
  logic [31:0]    B_RDATA;

  // SRAM macro
  logic           SRAMCS;
  logic [3:0]     SRAMWEN;
  logic [WAW-1:0] SRAMADDR;
  logic [31:0]    SRAMWDATA;
  logic [31:0]    SRAMRDATA;

  // Stall/status towards the subsystem wrapper
  logic           AHB_STALL;
  logic           STARVE_CNT_SAT;

  modport slave (
    input  A_SRAMCS, A_SRAMWEN, A_SRAMADDR, A_SRAMWDATA,
    output A_SRAMRDATA,
    input  B_REQ, B_WRITE, B_WEN, B_ADDR, B_WDATA,
    output B_GNT, B_RVALID, B_RDATA,
    output SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA,
    input  SRAMRDATA,
    output AHB_STALL, STARVE_CNT_SAT
  );

  modport master (
    output A_SRAMCS, A_SRAMWEN, A_SRAMADDR, A_SRAMWDATA,
    input  A_SRAMRDATA,
    output B_REQ, B_WRITE, B_WEN, B_ADDR, B_WDATA,
    input  B_GNT, B_RVALID, B_RDATA,
    input  SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA,
    output SRAMRDATA,
    input  AHB_STALL, STARVE_CNT_SAT
  );
endinterface

// File: rtl/sram_dma_port_arbiter.sv
// Single-port SRAM arbiter: AHB bridge (port A) has fixed priority and a combinational path,
// DMA (port B) takes idle cycles; a starvation FSM stalls the AHB bus for two cycles.
module sram_dma_port_arbiter #(
  parameter int unsigned AW           = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                   HCLK,
  input logic                   HRESET,
  sram_dma_port_arbiter_if.slave bus
);

  localparam int unsigned WAW = AW - 2;
  localparam int unsigned CW  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STALL1 = 2'd2,
    S_STALL2 = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           b_gnt;
  logic [WAW-1:0] b_addr;
  logic           ahb_stall_q;
  logic           starve_sat_q;
  logic           b_rvalid_q;
  logic           stall_d;

  assign b_gnt  = bus.B_REQ & ~bus.A_SRAMCS;
  assign b_addr = bus.B_ADDR;

  assign bus.B_GNT          = b_gnt;
  assign bus.A_SRAMRDATA    = bus.SRAMRDATA;
  assign bus.B_RDATA        = bus.SRAMRDATA;
  assign bus.B_RVALID       = b_rvalid_q;
  assign bus.AHB_STALL      = ahb_stall_q;
  assign bus.STARVE_CNT_SAT = starve_sat_q;

  // SRAM mux; address/data default to port A so the bridge path has no extra muxing when idle
  always_comb begin
    bus.SRAMCS    = 1'b0;
    bus.SRAMWEN   = 4'b0000;
    bus.SRAMADDR  = bus.A_SRAMADDR;
    bus.SRAMWDATA = bus.A_SRAMWDATA;
    if (bus.A_SRAMCS) begin
      bus.SRAMCS  = 1'b1;
      bus.SRAMWEN = bus.A_SRAMWEN;
    end else if (b_gnt) begin
      bus.SRAMCS    = 1'b1;
      bus.SRAMADDR  = b_addr;
      bus.SRAMWDATA = bus.B_WDATA;
      bus.SRAMWEN   = bus.B_WRITE ? bus.B_WEN : 4'b0000;
    end
  end

  // Starvation FSM: counts blocked DMA cycles, saturating into a two-cycle AHB stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.B_REQ && bus.A_SRAMCS) begin
          state_d = S_WAIT;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT: begin
        if (b_gnt || !bus.B_REQ) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STARVE_LIMIT)) begin
          state_d = S_STALL1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STALL1: begin
        state_d = S_STALL2;
        cnt_d   = '0;
      end
      S_STALL2: begin
        // a still-asserted A_SRAMCS here is a bridge violation; counting restarts from IDLE
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall_d = (state_d == S_STALL1) || (state_d == S_STALL2);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ahb_stall_q  <= 1'b0;
      starve_sat_q <= 1'b0;
      b_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ahb_stall_q  <= stall_d;
      starve_sat_q <= starve_sat_q | (state_d == S_STALL1);
      b_rvalid_q   <= b_gnt & ~bus.B_WRITE;
    end
  end

endmodule
